// File: rtl/int_to_fp_converter_pkg.sv
// Shared types for the integer-to-float converter: command, rounding mode, flags, FSM state.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package int_to_fp_converter_pkg;

    // FCVT.S.W treats the source as signed, FCVT.S.WU as unsigned
    typedef enum logic {
        CMD_SIGNED   = 1'b0,
        CMD_UNSIGNED = 1'b1
    } fp_int_cmd_t;

    // Resolved rounding mode as delivered by the decoder
    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rounding_mode_t;

    // Accrued exception flags in fflags bit order (NV is the MSB)
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    // Converter FSM
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_NORMALIZE = 2'd1,
        ST_ROUND     = 2'd2,
        ST_DONE      = 2'd3
    } cvt_state_t;

endpackage

// File: rtl/int_to_fp_converter_fp_rounder.sv
// Rounds a normalized significand (implied leading 1) using guard/sticky, sign and rounding mode.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module fp_rounder
    import int_to_fp_converter_pkg::*;
#(
    parameter int FRAC_W = 23
) (
    input  logic [FRAC_W-1:0] i_frac,
    input  logic              i_guard,
    input  logic              i_sticky,
    input  logic              i_sign,
    input  logic [2:0]        i_rm,
    output logic [FRAC_W-1:0] o_frac,
    output logic              o_carry,
    output logic              o_inexact
);

    logic              w_inc;
    logic [FRAC_W:0]   w_sum;

    // Decide whether to bump the significand; unknown encodings fall back to RNE
    always_comb begin
        w_inc = 1'b0;
        case (i_rm)
            RM_RNE:  w_inc = i_guard && (i_sticky || i_frac[0]);
            RM_RTZ:  w_inc = 1'b0;
            RM_RDN:  w_inc = i_sign && (i_guard || i_sticky);
            RM_RUP:  w_inc = !i_sign && (i_guard || i_sticky);
            RM_RMM:  w_inc = i_guard;
            default: w_inc = i_guard && (i_sticky || i_frac[0]);
        endcase
    end

    // Carry out of the fraction means 1.111..1 rolled over to 10.000..0:
    // the fraction wraps to zero and the caller bumps the exponent.
    assign w_sum     = {1'b0, i_frac} + {{FRAC_W{1'b0}}, w_inc};
    assign o_frac    = w_sum[FRAC_W-1:0];
    assign o_carry   = w_sum[FRAC_W];
    assign o_inexact = i_guard || i_sticky;

endmodule

// File: rtl/int_to_fp_converter.sv
// Integer to single-precision converter (FCVT.S.W / FCVT.S.WU); INT_TO_FP_FAST_NORMALIZE_EN selects one-cycle normalize.
// Latency: zero -> 1 cycle; otherwise 3+k cycles (k = leading zeros), or 3 cycles with fast normalize.
// Backpressure: ready only in IDLE; result held in DONE until resultReady, no overlap between operations.
module int_to_fp_converter
    import int_to_fp_converter_pkg::*;
#(
    parameter int EXPONENT_WIDTH = 8,
    parameter int FRACTION_WIDTH = 23,
    parameter int INT_WIDTH      = 32,
    parameter int WIDTH          = 1 + EXPONENT_WIDTH + FRACTION_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  fp_int_cmd_t          command,
    input  logic [INT_WIDTH-1:0] intSrc,
    input  logic [2:0]           roundingMode,
    input  logic                 valid,
    output logic                 ready,
    output logic [WIDTH-1:0]     fpResult,
    output fflags_t              flags,
    output logic                 resultValid,
    input  logic                 resultReady
);

    localparam int CNT_W = $clog2(INT_WIDTH);
    localparam int SIG_W = FRACTION_WIDTH + 1;
    localparam int BIAS  = (2 ** (EXPONENT_WIDTH - 1)) - 1;
    localparam int GUARD_POS = INT_WIDTH - SIG_W - 1;
    localparam logic [INT_WIDTH-1:0] STICKY_MASK =
        (INT_WIDTH'(1) << GUARD_POS) - INT_WIDTH'(1);

    cvt_state_t                r_state;
    cvt_state_t                w_next_state;
    logic                      r_sign;
    logic [INT_WIDTH-1:0]      r_mag;
    logic [2:0]                r_rm;
    logic [CNT_W-1:0]          r_count;
    logic [WIDTH-1:0]          r_fp_result;
    fflags_t                   r_flags;

    logic                      w_sign;
    logic [INT_WIDTH-1:0]      w_mag;
    logic                      w_guard;
    logic                      w_sticky;
    logic [FRACTION_WIDTH-1:0] w_frac;
    logic                      w_carry;
    logic                      w_nx;
    logic [EXPONENT_WIDTH-1:0] w_exp;

    // Sign/magnitude of the request; the most negative value maps to its own unsigned magnitude
    assign w_sign = (command == CMD_SIGNED) && intSrc[INT_WIDTH-1];
    assign w_mag  = w_sign ? (~intSrc + INT_WIDTH'(1)) : intSrc;

`ifdef INT_TO_FP_FAST_NORMALIZE_EN
    logic [CNT_W-1:0] w_lzc;

    // Leading-zero count of the captured magnitude (highest set bit wins)
    always_comb begin
        w_lzc = '0;
        for (int i = 0; i < INT_WIDTH; i++) begin
            if (r_mag[i]) begin
                w_lzc = CNT_W'(INT_WIDTH - 1 - i);
            end
        end
    end
`endif

    // Round fields taken from the normalized magnitude
    assign w_guard  = r_mag[GUARD_POS];
    assign w_sticky = |(r_mag & STICKY_MASK);

    fp_rounder #(
        .FRAC_W (FRACTION_WIDTH)
    ) u_rounder (
        .i_frac    (r_mag[INT_WIDTH-2 -: FRACTION_WIDTH]),
        .i_guard   (w_guard),
        .i_sticky  (w_sticky),
        .i_sign    (r_sign),
        .i_rm      (r_rm),
        .o_frac    (w_frac),
        .o_carry   (w_carry),
        .o_inexact (w_nx)
    );

    // Exponent follows the MSB position left after normalization, plus any rounding carry
    assign w_exp = EXPONENT_WIDTH'(BIAS + INT_WIDTH - 1)
                 - EXPONENT_WIDTH'(r_count)
                 + EXPONENT_WIDTH'(w_carry);

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (valid) begin
                    w_next_state = (w_mag == '0) ? ST_DONE : ST_NORMALIZE;
                end
            end
            ST_NORMALIZE: begin
`ifdef INT_TO_FP_FAST_NORMALIZE_EN
                w_next_state = ST_ROUND;
`else
                if (r_mag[INT_WIDTH-1]) begin
                    w_next_state = ST_ROUND;
                end
`endif
            end
            ST_ROUND: begin
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                if (resultReady) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Operand capture, normalization shift and result registration
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sign      <= 1'b0;
            r_mag       <= '0;
            r_rm        <= '0;
            r_count     <= '0;
            r_fp_result <= '0;
            r_flags     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (valid) begin
                        r_sign  <= w_sign;
                        r_mag   <= w_mag;
                        r_rm    <= roundingMode;
                        r_count <= '0;
                        if (w_mag == '0) begin
                            r_fp_result <= '0;
                            r_flags     <= '0;
                        end
                    end
                end
                ST_NORMALIZE: begin
`ifdef INT_TO_FP_FAST_NORMALIZE_EN
                    r_mag   <= r_mag << w_lzc;
                    r_count <= w_lzc;
`else
                    if (!r_mag[INT_WIDTH-1]) begin
                        r_mag   <= r_mag << 1;
                        r_count <= r_count + CNT_W'(1);
                    end
`endif
                end
                ST_ROUND: begin
                    r_fp_result <= {r_sign, w_exp, w_frac};
                    r_flags     <= '{nv: 1'b0, dz: 1'b0, of: 1'b0, uf: 1'b0, nx: w_nx};
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake outputs; ready is suppressed while reset is held
    assign ready       = (r_state == ST_IDLE) && rst;
    assign resultValid = (r_state == ST_DONE);
    assign fpResult    = r_fp_result;
    assign flags       = r_flags;

endmodule

// File: tb/tb_int_to_fp_converter.sv
// Bench for int_to_fp_converter: table of vectors plus reset and hold sequences, scoreboard queue.
// Latency: checks result latency per vector against the leading-zero count.
// Backpressure: exercises resultReady held low and reset during normalization.
module tb_int_to_fp_converter;
    import int_to_fp_converter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    fp_int_cmd_t command;
    logic [31:0] intSrc;
    logic [2:0]  roundingMode;
    logic        valid;
    logic        ready;
    logic [31:0] fpResult;
    fflags_t     flags;
    logic        resultValid;
    logic        resultReady;

    int total = 0;
    int bad   = 0;

    typedef struct {
        fp_int_cmd_t cmd;
        logic [31:0] src;
        logic [2:0]  rm;
        logic [31:0] res;
        logic        nx;
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  flg;
    } exp_t;

    vec_t vecs[16];
    exp_t sb_q[$];

    int_to_fp_converter dut (
        .clk          (clk),
        .rst          (rst),
        .command      (command),
        .intSrc       (intSrc),
        .roundingMode (roundingMode),
        .valid        (valid),
        .ready        (ready),
        .fpResult     (fpResult),
        .flags        (flags),
        .resultValid  (resultValid),
        .resultReady  (resultReady)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Expected latency in cycles from the accept edge to resultValid
    function automatic int exp_latency(input fp_int_cmd_t cmd, input logic [31:0] src);
        logic [31:0] mag;
        int k;
        mag = (cmd == CMD_SIGNED && src[31]) ? (~src + 32'd1) : src;
        if (mag == 32'd0) return 1;
        k = 0;
        while (!mag[31 - k]) k++;
`ifdef INT_TO_FP_FAST_NORMALIZE_EN
        return 3;
`else
        return k + 3;
`endif
    endfunction

    // Issue one request, check latency and result, optionally stall the consumer first
    task automatic run_req(input string tag, input fp_int_cmd_t cmd, input logic [31:0] src,
                           input logic [2:0] rm, input logic [31:0] res, input logic nx,
                           input int hold);
        int   n;
        int   lat;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " ready"}, ready, 1'b1);
        command      = cmd;
        intSrc       = src;
        roundingMode = rm;
        valid        = 1'b1;
        @(posedge clk);
        sb_q.push_back('{res: res, flg: {4'b0, nx}});
        #1;
        valid = 1'b0;
        lat   = 1;
        while (!resultValid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!resultValid) begin
            total++;
            bad++;
            $display("FAIL %s timeout: got no resultValid want one within 100 cycles", tag);
            sb_q.delete();
            return;
        end
        chk({tag, " latency"}, lat, exp_latency(cmd, src));
        e = sb_q.pop_front();
        chk({tag, " result"}, fpResult, e.res);
        chk({tag, " flags"}, flags, e.flg);
        for (int j = 0; j < hold; j++) begin
            @(posedge clk);
            #1;
            chk({tag, " hold valid"}, resultValid, 1'b1);
            chk({tag, " hold result"}, fpResult, e.res);
            chk({tag, " hold ready"}, ready, 1'b0);
        end
        @(negedge clk);
        resultReady = 1'b1;
        @(posedge clk);
        #1;
        resultReady = 1'b0;
        chk({tag, " released"}, resultValid, 1'b0);
    endtask

    initial begin
        int seen;

        vecs[0]  = '{CMD_SIGNED,   32'h0000_0001, 3'd0, 32'h3F80_0000, 1'b0};
        vecs[1]  = '{CMD_SIGNED,   32'hFFFF_FFFF, 3'd0, 32'hBF80_0000, 1'b0};
        vecs[2]  = '{CMD_SIGNED,   32'h8000_0000, 3'd0, 32'hCF00_0000, 1'b0};
        vecs[3]  = '{CMD_SIGNED,   32'h7FFF_FFFF, 3'd0, 32'h4F00_0000, 1'b1};
        vecs[4]  = '{CMD_SIGNED,   32'h7FFF_FFFF, 3'd1, 32'h4EFF_FFFF, 1'b1};
        vecs[5]  = '{CMD_UNSIGNED, 32'hFFFF_FFFF, 3'd0, 32'h4F80_0000, 1'b1};
        vecs[6]  = '{CMD_SIGNED,   32'h0100_0001, 3'd0, 32'h4B80_0000, 1'b1};
        vecs[7]  = '{CMD_SIGNED,   32'h0100_0001, 3'd3, 32'h4B80_0001, 1'b1};
        vecs[8]  = '{CMD_SIGNED,   32'h0100_0001, 3'd4, 32'h4B80_0001, 1'b1};
        vecs[9]  = '{CMD_SIGNED,   32'h0000_0000, 3'd0, 32'h0000_0000, 1'b0};
        vecs[10] = '{CMD_UNSIGNED, 32'h0000_0002, 3'd1, 32'h4000_0000, 1'b0};
        vecs[11] = '{CMD_SIGNED,   32'hFFFF_FFF9, 3'd0, 32'hC0E0_0000, 1'b0};
        vecs[12] = '{CMD_SIGNED,   32'hFEFF_FFFF, 3'd2, 32'hCB80_0001, 1'b1};
        vecs[13] = '{CMD_SIGNED,   32'hFEFF_FFFF, 3'd3, 32'hCB80_0000, 1'b1};
        vecs[14] = '{CMD_SIGNED,   32'h0100_0001, 3'd5, 32'h4B80_0000, 1'b1};
        vecs[15] = '{CMD_UNSIGNED, 32'h8000_0000, 3'd0, 32'h4F00_0000, 1'b0};

        rst          = 1'b0;
        valid        = 1'b0;
        resultReady  = 1'b0;
        command      = CMD_SIGNED;
        intSrc       = '0;
        roundingMode = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", ready, 1'b0);
        chk("reset resultValid", resultValid, 1'b0);
        chk("reset fpResult", fpResult, 32'h0);
        chk("reset flags", flags, 5'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_req($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].src, vecs[i].rm,
                    vecs[i].res, vecs[i].nx, 0);
        end

        // Zero operand with the consumer stalled for five cycles
        run_req("zero_hold", CMD_SIGNED, 32'h0, 3'd0, 32'h0, 1'b0, 5);

        // Reset while the long operand is in NORMALIZE: no result may appear
        @(negedge clk);
        command      = CMD_SIGNED;
        intSrc       = 32'h0000_0001;
        roundingMode = 3'd0;
        valid        = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        rst   = 1'b0;
        #1;
        chk("midrst ready", ready, 1'b0);
        chk("midrst resultValid", resultValid, 1'b0);
        repeat (2) @(negedge clk);
        rst  = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (resultValid) seen++;
        end
        chk("midrst no result", seen, 0);
        chk("midrst ready after", ready, 1'b1);
        run_req("after_rst", CMD_SIGNED, 32'h0000_0002, 3'd0, 32'h4000_0000, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
